// File: rtl/alu_4bit.sv
// alu_4bit: 4-bit registered ALU with 16 opcodes covering arithmetic, logic,
// shift, rotate and compare. The result, carry/borrow and zero flag are all
// registered on the same edge, so every output belongs to one operation.
module alu_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [3:0] ALU_Out,
    output logic       CarryOut,
    output logic       ZeroFlag
);

    // Opcode encoding
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_ROL  = 4'b0111;
    localparam logic [3:0] OP_ROR  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_NAND = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_XNOR = 4'b1100;
    localparam logic [3:0] OP_GT   = 4'b1101;
    localparam logic [3:0] OP_EQ   = 4'b1110;
    localparam logic [3:0] OP_PASS = 4'b1111;

    logic [3:0] and_vec;
    logic [3:0] or_vec;
    logic [3:0] xor_vec;
    logic [4:0] sum_ext;
    logic [4:0] diff_ext;

    logic [3:0] alu_out_reg;
    logic [3:0] alu_out_next;
    logic       carry_reg;
    logic       carry_next;
    logic       zero_reg;
    logic       zero_next;

    // Per-bit logic terms; the inverted ops reuse these.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bitwise
            assign and_vec[gi] = A[gi] & B[gi];
            assign or_vec[gi]  = A[gi] | B[gi];
            assign xor_vec[gi] = A[gi] ^ B[gi];
        end
    endgenerate

    // Zero-extended so bit 4 is the carry on add and the borrow on subtract.
    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};

    // Next result and carry; every opcode is decoded, so no X branch.
    always_comb begin
        alu_out_next = 4'b0000;
        carry_next   = 1'b0;
        unique case (ALU_Sel)
            OP_ADD: begin
                alu_out_next = sum_ext[3:0];
                carry_next   = sum_ext[4];
            end
            OP_SUB: begin
                alu_out_next = diff_ext[3:0];
                carry_next   = diff_ext[4];
            end
            OP_AND:  alu_out_next = and_vec;
            OP_OR:   alu_out_next = or_vec;
            OP_XOR:  alu_out_next = xor_vec;
            OP_SHL: begin
                alu_out_next = {A[2:0], 1'b0};
                carry_next   = A[3];
            end
            OP_SHR: begin
                alu_out_next = {1'b0, A[3:1]};
                carry_next   = A[0];
            end
            OP_ROL: begin
                alu_out_next = {A[2:0], A[3]};
                carry_next   = A[3];
            end
            OP_ROR: begin
                alu_out_next = {A[0], A[3:1]};
                carry_next   = A[0];
            end
            OP_NOT:  alu_out_next = ~A;
            OP_NAND: alu_out_next = ~and_vec;
            OP_NOR:  alu_out_next = ~or_vec;
            OP_XNOR: alu_out_next = ~xor_vec;
            OP_GT:   alu_out_next = {3'b000, (A > B)};
            OP_EQ:   alu_out_next = {3'b000, (A == B)};
            OP_PASS: alu_out_next = A;
            default: alu_out_next = 4'b0000;
        endcase
        zero_next = (alu_out_next == 4'b0000);
    end

    // Output registers; reset wins over any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_reg <= 4'b0000;
            carry_reg   <= 1'b0;
            zero_reg    <= 1'b1;
        end else begin
            alu_out_reg <= alu_out_next;
            carry_reg   <= carry_next;
            zero_reg    <= zero_next;
        end
    end

    assign ALU_Out  = alu_out_reg;
    assign CarryOut = carry_reg;
    assign ZeroFlag = zero_reg;

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed vector table, a latency probe, a reset-mid-stream
// sequence and randomized traffic checked against an arithmetic model.
module tb_alu_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] ALU_Sel;
    logic [3:0] ALU_Out;
    logic       CarryOut;
    logic       ZeroFlag;

    int checks = 0;
    int errors = 0;

    alu_4bit dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .ALU_Sel  (ALU_Sel),
        .ALU_Out  (ALU_Out),
        .CarryOut (CarryOut),
        .ZeroFlag (ZeroFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
        logic [3:0] out;
        logic       c;
        logic       z;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    // Reference model written from the operation rules using integer math.
    function automatic void model(input int a, input int b, input int sel,
                                  output int out, output int c);
        out = 0;
        c   = 0;
        case (sel)
            0:  begin out = (a + b) % 16; c = (a + b) / 16; end
            1:  begin out = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            2:  out = a & b;
            3:  out = a | b;
            4:  out = a ^ b;
            5:  begin out = (a * 2) % 16; c = a / 8; end
            6:  begin out = a / 2; c = a % 2; end
            7:  begin out = (a * 2) % 16 + a / 8; c = a / 8; end
            8:  begin out = a / 2 + (a % 2) * 8; c = a % 2; end
            9:  out = 15 - a;
            10: out = 15 - (a & b);
            11: out = 15 - (a | b);
            12: out = 15 - (a ^ b);
            13: out = (a > b) ? 1 : 0;
            14: out = (a == b) ? 1 : 0;
            default: out = a;
        endcase
    endfunction

    task automatic compare(input string name, input logic [3:0] eo,
                           input logic ec, input logic ez);
        checks++;
        if (ALU_Out !== eo || CarryOut !== ec || ZeroFlag !== ez) begin
            errors++;
            $display("FAIL %s: got out=%b c=%b z=%b, expected out=%b c=%b z=%b",
                     name, ALU_Out, CarryOut, ZeroFlag, eo, ec, ez);
        end else begin
            $display("ok   %s: out=%b c=%b z=%b", name, ALU_Out, CarryOut, ZeroFlag);
        end
    endtask

    // Drive one transaction away from the edge, then check after the edge.
    task automatic step(input string name, input logic r, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] sel,
                        input logic [3:0] eo, input logic ec, input logic ez);
        @(negedge clk);
        rst = r; A = a; B = b; ALU_Sel = sel;
        @(posedge clk);
        #1;
        compare(name, eo, ec, ez);
    endtask

    initial begin
        int eo, ec;
        logic [3:0] prev_o;
        logic       prev_c, prev_z;
        logic       r;
        logic [3:0] a, b, s;

        vecs[0]  = '{"reset",    1'b1, 4'd5,    4'd9,    4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[1]  = '{"add_7_8",  1'b0, 4'd7,    4'd8,    4'b0000, 4'b1111, 1'b0, 1'b0};
        vecs[2]  = '{"sub_9_3",  1'b0, 4'd9,    4'd3,    4'b0001, 4'b0110, 1'b0, 1'b0};
        vecs[3]  = '{"add_wrap", 1'b0, 4'd15,   4'd1,    4'b0000, 4'b0000, 1'b1, 1'b1};
        vecs[4]  = '{"sub_0_1",  1'b0, 4'd0,    4'd1,    4'b0001, 4'b1111, 1'b1, 1'b0};
        vecs[5]  = '{"sub_5_5",  1'b0, 4'd5,    4'd5,    4'b0001, 4'b0000, 1'b0, 1'b1};
        vecs[6]  = '{"and",      1'b0, 4'b1010, 4'b1100, 4'b0010, 4'b1000, 1'b0, 1'b0};
        vecs[7]  = '{"or",       1'b0, 4'b1010, 4'b0101, 4'b0011, 4'b1111, 1'b0, 1'b0};
        vecs[8]  = '{"xor",      1'b0, 4'b1111, 4'b1010, 4'b0100, 4'b0101, 1'b0, 1'b0};
        vecs[9]  = '{"nand_z",   1'b0, 4'b1111, 4'b1111, 4'b1010, 4'b0000, 1'b0, 1'b1};
        vecs[10] = '{"not",      1'b0, 4'b1001, 4'b0110, 4'b1001, 4'b0110, 1'b0, 1'b0};
        vecs[11] = '{"shl",      1'b0, 4'b1001, 4'b1111, 4'b0101, 4'b0010, 1'b1, 1'b0};
        vecs[12] = '{"shr",      1'b0, 4'b1001, 4'b0000, 4'b0110, 4'b0100, 1'b1, 1'b0};
        vecs[13] = '{"rol",      1'b0, 4'b1001, 4'b0101, 4'b0111, 4'b0011, 1'b1, 1'b0};
        vecs[14] = '{"ror",      1'b0, 4'b1001, 4'b1010, 4'b1000, 4'b1100, 1'b1, 1'b0};
        vecs[15] = '{"shl_0111", 1'b0, 4'b0111, 4'b1111, 4'b0101, 4'b1110, 1'b0, 1'b0};
        vecs[16] = '{"gt_9_3",   1'b0, 4'd9,    4'd3,    4'b1101, 4'b0001, 1'b0, 1'b0};
        vecs[17] = '{"gt_3_9",   1'b0, 4'd3,    4'd9,    4'b1101, 4'b0000, 1'b0, 1'b1};
        vecs[18] = '{"eq_6_6",   1'b0, 4'd6,    4'd6,    4'b1110, 4'b0001, 1'b0, 1'b0};
        vecs[19] = '{"pass",     1'b0, 4'b1010, 4'b0011, 4'b1111, 4'b1010, 1'b0, 1'b0};
        vecs[20] = '{"nor",      1'b0, 4'b1010, 4'b0100, 4'b1011, 4'b0001, 1'b0, 1'b0};
        vecs[21] = '{"xnor",     1'b0, 4'b1100, 4'b1010, 4'b1100, 4'b1001, 1'b0, 1'b0};

        rst = 1'b1; A = 4'd0; B = 4'd0; ALU_Sel = 4'd0;

        // Directed table, one opcode change per cycle.
        for (int i = 0; i < NVEC; i++)
            step(vecs[i].name, vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].sel,
                 vecs[i].out, vecs[i].c, vecs[i].z);

        // Latency probe: new inputs must not show before the next edge.
        step("lat_pre", 1'b0, 4'd3, 4'd4, 4'b0000, 4'b0111, 1'b0, 1'b0);
        @(negedge clk);
        A = 4'd9; B = 4'd9; ALU_Sel = 4'b0001;
        #2;
        compare("lat_hold", 4'b0111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        compare("lat_after", 4'b0000, 1'b0, 1'b1);

        // Reset asserted during a stream of ADDs.
        step("add_s1", 1'b0, 4'd2, 4'd3, 4'b0000, 4'd5, 1'b0, 1'b0);
        step("add_s2", 1'b0, 4'd9, 4'd9, 4'b0000, 4'd2, 1'b1, 1'b0);
        step("add_rst", 1'b1, 4'd9, 4'd9, 4'b0000, 4'd0, 1'b0, 1'b1);
        step("add_rel", 1'b0, 4'd4, 4'd4, 4'b0000, 4'd8, 1'b0, 1'b0);

        // Randomized back-to-back traffic with occasional reset.
        prev_o = 4'd8; prev_c = 1'b0; prev_z = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 19) == 0);
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            s = 4'($urandom_range(0, 15));
            model(int'(a), int'(b), int'(s), eo, ec);
            if (r) begin
                eo = 0;
                ec = 0;
            end
            @(negedge clk);
            rst = r; A = a; B = b; ALU_Sel = s;
            #1;
            if (i % 50 == 0) compare($sformatf("rnd_hold_%0d", i), prev_o, prev_c, prev_z);
            @(posedge clk);
            #1;
            compare($sformatf("rnd_%0d r=%0b sel=%0d a=%0d b=%0d", i, r, s, a, b),
                    4'(eo), ec[0], (eo == 0));
            prev_o = 4'(eo); prev_c = ec[0]; prev_z = (eo == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
